// File: rtl/parity_rr_sequencer_if.sv
// Handshake bundle between the four requesters and the shared parity sequencer.
//   req       : request lines, bit i = requester i
//   req_data  : flattened words, requester i owns [i*DATA_W +: DATA_W]
//   grant     : one-hot capture pulse back to the requesters
//   busy      : word reduction in progress
//   done      : one-cycle pulse, result/done_id valid
//   done_id   : requester that owns the result
//   result    : 1 = even number of ones
// master = requester side, slave = sequencer side.
interface parity_rr_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          req;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          grant;
  logic                busy;
  logic                done;
  logic [1:0]          done_id;
  logic                result;

  modport master (
    output req, req_data,
    input  grant, busy, done, done_id, result
  );

  modport slave (
    input  req, req_data,
    output grant, busy, done, done_id, result
  );
endinterface

// File: rtl/parity_rr_sequencer.sv
// Shared even-parity engine for four requesters. A round-robin arbiter
// captures one requester's word, which is then folded 2 bits per cycle into
// a single parity flag. The result comes back tagged with the requester id.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : parity_rr_if slave modport (req/req_data in; grant/busy/done/
//            done_id/result out, all registered)
//
//   state | meaning
//   IDLE  | waiting for a request, arbitration active
//   RUN   | reducing the captured word, 2 bits per cycle
module parity_rr_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  parity_rr_if.slave bus
);

  localparam int STEPS = DATA_W / 2;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        cur_id;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     count;
  logic              e;
  logic              e_next;

  logic [1:0]        pick_id;
  logic [1:0]        cand;
  logic              pick_valid;

  // One fold step: xnor(~e, sr[0], sr[1]) reduces to a plain xor chain.
  assign e_next = e ^ sr[0] ^ sr[1];

  // Search starts just after the last granted requester so a continuously
  // requesting peer can never be skipped twice in a row.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = ptr;
    cand       = ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      cur_id      <= 2'd0;
      sr          <= '0;
      count       <= '0;
      e           <= 1'b1;
      bus.grant   <= 4'b0000;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 2'd0;
      bus.result  <= 1'b0;
    end else begin
      bus.grant <= 4'b0000;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.grant <= 4'b0001 << pick_id;
            ptr       <= pick_id;
            cur_id    <= pick_id;
            sr        <= bus.req_data[pick_id*DATA_W +: DATA_W];
            e         <= 1'b1;
            count     <= CW'(STEPS);
            bus.busy  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          e     <= e_next;
          sr    <= sr >> 2;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.done    <= 1'b1;
            bus.result  <= e_next;
            bus.done_id <= cur_id;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_rr_sequencer.sv
module tb_parity_rr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  parity_rr_if #(.DATA_W(8)) b8();
  parity_rr_if #(.DATA_W(2)) b2();

  parity_rr_sequencer #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  parity_rr_sequencer #(.DATA_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       exp_res;
  } vec_t;

  typedef struct {
    int   edge_no;
    int   id;
    logic res;
  } exp_t;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] r8;
  logic [7:0] d8 [4];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8();
    b8.req = r8;
    for (int i = 0; i < 4; i++) b8.req_data[i*8 +: 8] = d8[i];
  endtask

  function automatic logic even_par(logic [7:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  function automatic int oh2id(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    r8 = 4'b0000;
    drive8();
    repeat (12) tick();
  endtask

  task automatic run_single(vec_t v, int idx);
    int  k;
    int  lat;
    bit  got;
    r8 = 4'b0001 << v.id;
    d8[v.id] = v.data;
    drive8();
    got = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (b8.grant != 0) begin got = 1; break; end
    end
    chk($sformatf("vec%0d_grant", idx), b8.grant, 4'b0001 << v.id);
    if (!got) return;
    chk($sformatf("vec%0d_busy", idx), b8.busy, 1);
    r8 = 4'b0000;
    d8[v.id] = ~v.data;
    drive8();
    lat = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (b8.done) break;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 4);
    chk($sformatf("vec%0d_done_id", idx), b8.done_id, v.id);
    chk($sformatf("vec%0d_result", idx), b8.result, v.exp_res);
    tick();
    chk($sformatf("vec%0d_done_pulse", idx), b8.done, 0);
    chk($sformatf("vec%0d_result_hold", idx), b8.result, v.exp_res);
    chk($sformatf("vec%0d_busy_off", idx), b8.busy, 0);
  endtask

  task automatic random_test();
    exp_t       q[$];
    int         mptr;
    int         free_e;
    int         g_e;
    int         gid;
    logic [3:0] eg;
    bit         ed;
    mptr = 3; free_e = 0; g_e = -100; gid = 0;
    for (int e = 0; e < 700; e++) begin
      if (e < 640)
        for (int i = 0; i < 4; i++)
          if (!r8[i] && $urandom_range(0, 2) == 0) begin
            r8[i] = 1'b1;
            d8[i] = 8'($urandom);
          end
      drive8();
      eg = 4'b0000;
      if (e >= free_e && r8 != 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (r8[(mptr + k) % 4]) begin gid = (mptr + k) % 4; break; end
        end
        eg     = 4'b0001 << gid;
        mptr   = gid;
        g_e    = e;
        free_e = e + 5;
        q.push_back('{e + 4, gid, even_par(d8[gid])});
      end
      tick();
      chk("rnd_grant", b8.grant, eg);
      chk("rnd_busy", b8.busy, (e >= g_e && e < g_e + 4));
      ed = (q.size() > 0) && (q[0].edge_no == e);
      chk("rnd_done", b8.done, ed);
      if (ed) begin
        chk("rnd_done_id", b8.done_id, q[0].id);
        chk("rnd_result", b8.result, q[0].res);
        void'(q.pop_front());
      end
      if (eg != 0) begin
        r8[gid] = 1'b0;
        d8[gid] = 8'($urandom);
      end
    end
    chk("rnd_queue_empty", q.size(), 0);
  endtask

  initial begin
    vec_t       vecs [8];
    logic       t3_exp [4];
    int         gcnt, dcnt, glast, prev, id, k, rearm;
    bit         got, seen_done;

    vecs[0] = '{2'd0, 8'h00, 1'b1};
    vecs[1] = '{2'd0, 8'h07, 1'b0};
    vecs[2] = '{2'd0, 8'hFF, 1'b1};
    vecs[3] = '{2'd0, 8'h80, 1'b0};
    vecs[4] = '{2'd2, 8'hA5, 1'b1};
    vecs[5] = '{2'd1, 8'h01, 1'b0};
    vecs[6] = '{2'd3, 8'hFE, 1'b0};
    vecs[7] = '{2'd3, 8'h3C, 1'b1};

    r8 = 4'b0000;
    for (int i = 0; i < 4; i++) d8[i] = 8'h00;
    drive8();
    b2.req = 4'b0000;
    b2.req_data = 8'h00;

    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", b8.grant, 0);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_done_id", b8.done_id, 0);
    chk("rst_result", b8.result, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // all four request at once, pointer starts at 3
    d8[0] = 8'h01; d8[1] = 8'h03; d8[2] = 8'h07; d8[3] = 8'h0F;
    t3_exp[0] = 1'b0; t3_exp[1] = 1'b1; t3_exp[2] = 1'b0; t3_exp[3] = 1'b1;
    r8 = 4'b1111;
    drive8();
    gcnt = 0; dcnt = 0; glast = 0;
    for (int c = 0; c < 60 && dcnt < 4; c++) begin
      tick();
      if (b8.grant != 0) begin
        id = oh2id(b8.grant);
        chk("t3_grant_onehot", $countones(b8.grant), 1);
        chk("t3_grant_order", id, gcnt);
        if (gcnt > 0) chk("t3_grant_spacing", c - glast, 5);
        glast = c;
        gcnt++;
        if (id >= 0) r8[id] = 1'b0;
        drive8();
      end
      if (b8.done) begin
        chk("t3_done_id", b8.done_id, dcnt);
        chk("t3_result", b8.result, t3_exp[dcnt]);
        dcnt++;
      end
    end
    chk("t3_done_count", dcnt, 4);
    drain();

    // single-requester vectors
    foreach (vecs[i]) run_single(vecs[i], i);
    drain();

    // fairness: requesters 1 and 3 re-request right after each grant
    r8 = 4'b1010;
    d8[1] = 8'h5A; d8[3] = 8'hC3;
    drive8();
    gcnt = 0; prev = -1; rearm = -1;
    for (int c = 0; c < 200 && gcnt < 12; c++) begin
      tick();
      if (rearm >= 0) begin r8[rearm] = 1'b1; rearm = -1; drive8(); end
      if (b8.grant != 0) begin
        id = oh2id(b8.grant);
        chk("t4_id_valid", (id == 1 || id == 3), 1);
        if (prev >= 0) chk("t4_alternate", (id != prev), 1);
        prev = id;
        gcnt++;
        if (id >= 0) r8[id] = 1'b0;
        rearm = id;
        drive8();
      end
    end
    chk("t4_grant_count", gcnt, 12);
    drain();

    do_reset();
    random_test();
    drain();

    // reset in the middle of a reduction
    r8 = 4'b0001; d8[0] = 8'h5A;
    drive8();
    got = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (b8.grant != 0) begin got = 1; break; end
    end
    chk("t5_grant_seen", got, 1);
    r8 = 4'b0000;
    drive8();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", b8.grant, 0);
    chk("t5_rst_busy", b8.busy, 0);
    chk("t5_rst_done", b8.done, 0);
    chk("t5_rst_done_id", b8.done_id, 0);
    chk("t5_rst_result", b8.result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    repeat (6) begin
      tick();
      if (b8.done) seen_done = 1;
    end
    chk("t5_no_done", seen_done, 0);
    r8 = 4'b1100; d8[2] = 8'h11; d8[3] = 8'h10;
    drive8();
    got = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (b8.grant != 0) begin got = 1; break; end
    end
    chk("t5_first_grant", b8.grant, 4'b0100);
    r8[2] = 1'b0;
    drive8();
    got = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (b8.grant != 0) begin got = 1; break; end
    end
    chk("t5_second_grant", b8.grant, 4'b1000);
    r8 = 4'b0000;
    drive8();
    drain();

    // DATA_W=2 instance: single-step reduction, late data change ignored
    b2.req = 4'b0100;
    b2.req_data = 8'b00_10_00_00;
    got = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (b2.grant != 0) begin got = 1; break; end
    end
    chk("t6_grant", b2.grant, 4'b0100);
    b2.req = 4'b0000;
    b2.req_data[5:4] = 2'b11;
    tick();
    chk("t6_done", b2.done, 1);
    chk("t6_result", b2.result, 0);
    chk("t6_done_id", b2.done_id, 2);
    tick();
    chk("t6_done_pulse", b2.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/parity_rr_sequencer.md
Name: parity_rr_sequencer

Overview:
Shared even-parity engine for four requesters. A round-robin arbiter grants one requester at a time and latches its DATA_W-bit word. The word is then reduced serially, 2 bits per cycle, through a single 3-input XNOR-style parity step. Each result is returned with the id of the requester it belongs to. The block sits between requester blocks and the one shared parity resource, so no requester needs its own parity tree.

Parameters:
DATA_W, 8, word width in bits; must be even and >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request lines; bit i = requester i.
req_data  input  4*DATA_W  flattened words; requester i owns bits [i*DATA_W +: DATA_W].
grant  output  4  one-hot, registered, single-cycle pulse; marks the cycle in which the word was captured.
busy  output  1  high while a word is being reduced (state RUN).
done  output  1  single-cycle pulse; result and done_id are valid.
done_id  output  2  id of the requester whose result is on result.
result  output  1  1 = even number of ones in the word (XNOR semantics); 0 = odd.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low, and clears all state immediately.
- Reset values:
  - grant=0, busy=0, done=0, done_id=0, result=0.
  - state=IDLE, rr pointer=3 (requester 0 has first priority).
  - shift register=0, count=0, parity flag e=1.
- FSM states: IDLE and RUN.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  - On that edge: grant<=onehot(id); ptr<=id; sr<=that requester's word; e<=1; count<=DATA_W/2; cur_id<=id; state<=RUN.
  - If no req bit is set, stay in IDLE; grant=0.
- RUN, each edge:
  - e<=e^sr[0]^sr[1], which equals xnor(~e, sr[0], sr[1]).
  - sr<=sr>>2; count<=count-1.
  - grant returns to 0.
- RUN, final step (count==1):
  - done<=1, result<=new e, done_id<=cur_id, state<=IDLE.
- Latency:
  - Grant at edge k; done is high in the cycle after edge k+DATA_W/2.
  - Back-to-back: the next grant can occur at the edge after done is set, giving one word per DATA_W/2+1 cycles.
- Hold rules:
  - result and done_id hold their values until the next done.
  - done is high for exactly 1 cycle.
- Handshake:
  - Requester holds req and its data stable until it sees its grant bit. Data is sampled on the grant edge.
  - Requester must drop req in the cycle grant is seen. A req still high when the FSM returns to IDLE is treated as a new request.
  - req changes during RUN are ignored. The latched word is unaffected by later req_data changes.
- Simultaneous requests: strict round-robin. No requester is granted twice while another has been continuously requesting.
- Reset mid-RUN: the in-flight word is discarded, no done is produced, and the pointer returns to 3.

Test Plan:
1. DATA_W=8, req=0001, data0=8'h00 -> grant=0001 for 1 cycle; busy high 4 cycles; done 4 cycles after grant with result=1, done_id=0.
2. req0 with data0=8'h07 -> result=0; then data0=8'hFF -> result=1; then data0=8'h80 -> result=0.
3. req=1111 held, each requester drops its req on its grant; words 8'h01/8'h03/8'h07/8'h0F -> grants in order 0,1,2,3; done_id 0,1,2,3 with results 0,1,0,1; grant spacing 5 cycles.
4. Fairness: req1 and req3 re-asserted immediately after each grant for 6 rounds -> grants alternate 1,3,1,3,...; no repeat while the other is pending.
5. rst_n low 2 cycles after grant (mid-RUN) -> all outputs at reset values immediately, no done; after release, req2 is granted before req3 when both are asserted (pointer = 3).
6. DATA_W=2, req=0100, data2=2'b10 -> done 1 cycle after grant, result=0, done_id=2; req_data changed during RUN does not affect result.
